// File: rtl/ram_burst_ctrl_if.sv
// ============================================================================
// Module      : ram_burst_ctrl_if
// Description : Request, write-data, read-data and RAM-side bundle for the
//               burst RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_burst_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wr;
    logic              mem_rd;
    logic              mem_cs;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, mem_data_out,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy,
               mem_addr, mem_data_in, mem_wr, mem_rd, mem_cs
    );

    modport master (
        output req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, mem_data_out,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy,
               mem_addr, mem_data_in, mem_wr, mem_rd, mem_cs
    );
endinterface

`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst read/write controller for a single-port RAM; one write
//               per accepted beat, one read beat every two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ram_burst_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_WAIT  = 3'd1,
        WR_PULSE = 3'd2,
        RD_PULSE = 3'd3,
        RD_CAP   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_rem, w_rem_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_din, w_mem_din_nxt;
    logic              r_mem_wr, w_mem_wr_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic              r_mem_cs, w_mem_cs_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_rvalid, w_rvalid_nxt;
    logic              r_rlast, w_rlast_nxt;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_cs   <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_cs   <= w_mem_cs_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rlast    <= w_rlast_nxt;
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // RAM strobes default low every cycle, so each access lasts one cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_rem_nxt      = r_rem;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_wr_nxt   = 1'b0;
        w_mem_rd_nxt   = 1'b0;
        w_mem_cs_nxt   = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_rvalid_nxt   = 1'b0;
        w_rlast_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_addr_nxt = bus.req_addr;
                    w_rem_nxt  = bus.req_len;
                    if (bus.req_wr) begin
                        w_state_nxt = WR_WAIT;
                    end else begin
                        w_state_nxt    = RD_PULSE;
                        w_mem_addr_nxt = bus.req_addr;
                        w_mem_rd_nxt   = 1'b1;
                        w_mem_cs_nxt   = 1'b1;
                    end
                end
            end
            WR_WAIT: begin
                if (bus.wdata_valid) begin
                    w_state_nxt    = WR_PULSE;
                    w_mem_addr_nxt = r_addr;
                    w_mem_din_nxt  = bus.wdata;
                    w_mem_wr_nxt   = 1'b1;
                    w_mem_cs_nxt   = 1'b1;
                end
            end
            WR_PULSE: begin
                if (r_rem == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WR_WAIT;
                    w_rem_nxt   = r_rem - c_len_one;
                    w_addr_nxt  = r_addr + c_addr_one;
                end
            end
            RD_PULSE: begin
                w_state_nxt = RD_CAP;
            end
            RD_CAP: begin
                // mem_addr is still held here, so the RAM output is stable to sample.
                w_rdata_nxt  = bus.mem_data_out;
                w_rvalid_nxt = 1'b1;
                w_rlast_nxt  = (r_rem == '0);
                if (r_rem == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt    = RD_PULSE;
                    w_rem_nxt      = r_rem - c_len_one;
                    w_addr_nxt     = r_addr + c_addr_one;
                    w_mem_addr_nxt = r_addr + c_addr_one;
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_cs_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.wdata_ready = (r_state == WR_WAIT);
    assign bus.rdata_valid = r_rvalid;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_last  = r_rlast;
    assign bus.busy        = r_busy;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_din;
    assign bus.mem_wr      = r_mem_wr;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.mem_cs      = r_mem_cs;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Directed self-checking bench for ram_burst_ctrl with a
//               synchronous RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_ctrl;

    logic clk;
    logic rst_n;

    ram_burst_ctrl_if #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) bus ();

    ram_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [1024];
    logic [7:0] ram_q;
    assign bus.mem_data_out = ram_q;

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_wr) ram[bus.mem_addr] <= bus.mem_data_in;
        if (bus.mem_cs && bus.mem_rd) ram_q <= ram[bus.mem_addr];
    end

    logic [9:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] rd_data_q [$];
    logic       rd_last_q [$];
    int         rd_pulses;
    int         viol;

    // Every output is registered, so one negedge sample sees each one-cycle pulse once.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr && bus.mem_rd) viol++;
            if ((bus.mem_wr || bus.mem_rd) && !bus.mem_cs) viol++;
            if ((!bus.busy || bus.wdata_ready) && bus.mem_cs) viol++;
            if (bus.mem_wr) begin
                wr_addr_q.push_back(bus.mem_addr);
                wr_data_q.push_back(bus.mem_data_in);
            end
            if (bus.mem_rd) rd_pulses++;
            if (bus.rdata_valid) begin
                rd_data_q.push_back(bus.rdata);
                rd_last_q.push_back(bus.rdata_last);
            end
        end
    end

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_data_q.delete();
        rd_last_q.delete();
    endtask

    task automatic start_req(input logic wr, input logic [9:0] a, input logic [7:0] l);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wbeat(input logic [7:0] d);
        int n = 0;
        bus.wdata_valid = 1'b1;
        bus.wdata       = d;
        while (!bus.wdata_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wdata_ready_seen", {31'd0, bus.wdata_ready}, 32'd1);
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("idle_reached", {31'd0, bus.busy}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    logic [9:0] exp_a [4];
    logic [7:0] exp_d [4];
    logic [7:0] exp_r8 [9];
    int         cyc;
    int         bad;
    int         n;
    int         snap_rd;
    int         snap_pulses;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram_q           = 8'h00;
        n_checks        = 0;
        n_errors        = 0;
        viol            = 0;
        rd_pulses       = 0;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_wr      = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;

        #12;
        check("rst_busy",      {31'd0, bus.busy},        32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready},   32'd1);
        check("rst_mem_cs",    {31'd0, bus.mem_cs},      32'd0);
        check("rst_mem_addr",  {22'd0, bus.mem_addr},    32'd0);
        check("rst_rvalid",    {31'd0, bus.rdata_valid}, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read at 0x005
        clear_logs();
        start_req(1'b1, 10'h005, 8'd0);
        wbeat(8'hA5);
        wait_idle();
        check("t1_wr_count", wr_addr_q.size(), 32'd1);
        check("t1_wr_addr",  {22'd0, wr_addr_q[0]}, 32'h005);
        check("t1_wr_data",  {24'd0, wr_data_q[0]}, 32'hA5);
        start_req(1'b0, 10'h005, 8'd0);
        wait_idle();
        check("t1_rd_count", rd_data_q.size(), 32'd1);
        check("t1_rd_data",  {24'd0, rd_data_q[0]}, 32'hA5);
        check("t1_rd_last",  {31'd0, rd_last_q[0]}, 32'd1);

        // Wrapping 4-beat write and read-back
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_logs();
        start_req(1'b1, 10'h3FE, 8'd3);
        for (int i = 0; i < 4; i++) wbeat(exp_d[i]);
        wait_idle();
        check("t2_wr_count", wr_addr_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_wr_addr", {22'd0, wr_addr_q[i]}, {22'd0, exp_a[i]});
            check("t2_wr_data", {24'd0, wr_data_q[i]}, {24'd0, exp_d[i]});
        end
        start_req(1'b0, 10'h3FE, 8'd3);
        wait_idle();
        check("t2_rd_count", rd_data_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_rd_data", {24'd0, rd_data_q[i]}, {24'd0, exp_d[i]});
            check("t2_rd_last", {31'd0, rd_last_q[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Write stall of 5 cycles between beats
        clear_logs();
        start_req(1'b1, 10'h100, 8'd1);
        wbeat(8'h55);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_busy",   {31'd0, bus.busy},        32'd1);
            check("t3_stall_wready", {31'd0, bus.wdata_ready}, 32'd1);
            check("t3_stall_mem_wr", {31'd0, bus.mem_wr},      32'd0);
            @(posedge clk); #1;
        end
        check("t3_wr_before_b2", wr_addr_q.size(), 32'd1);
        wbeat(8'h66);
        wait_idle();
        check("t3_wr_count", wr_addr_q.size(), 32'd2);
        check("t3_wr_addr2", {22'd0, wr_addr_q[1]}, 32'h101);
        check("t3_wr_data2", {24'd0, wr_data_q[1]}, 32'h66);

        // Busy rejection during an 8-beat read; held request taken on first IDLE
        exp_r8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5};
        clear_logs();
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 10'h3FE;
        bus.req_len   = 8'd7;
        @(posedge clk); #1;
        bus.req_addr  = 10'h005;
        bus.req_len   = 8'd0;
        cyc = 0;
        bad = 0;
        while (bus.busy && cyc < 200) begin
            if (bus.req_ready) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check("t4_ready_while_busy", bad, 32'd0);
        check("t4_busy_cycles",      cyc, 32'd16);
        @(posedge clk); #1;
        check("t4_second_accepted", {31'd0, bus.busy}, 32'd1);
        bus.req_valid = 1'b0;
        wait_idle();
        check("t4_rd_count", rd_data_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check("t4_rd_data", {24'd0, rd_data_q[i]}, {24'd0, exp_r8[i]});
            check("t4_rd_last", {31'd0, rd_last_q[i]}, (i >= 7) ? 32'd1 : 32'd0);
        end

        // Reset during beat 2 of a 6-beat read
        clear_logs();
        start_req(1'b0, 10'h000, 8'd5);
        n = 0;
        while (!bus.rdata_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("t5_beat1_seen", {31'd0, bus.rdata_valid}, 32'd1);
        check("t5_beat1_data", {24'd0, bus.rdata},       32'h33);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy",     {31'd0, bus.busy},        32'd0);
        check("t5_rst_mem_addr", {22'd0, bus.mem_addr},    32'd0);
        check("t5_rst_mem_din",  {24'd0, bus.mem_data_in}, 32'd0);
        check("t5_rst_mem_rd",   {31'd0, bus.mem_rd},      32'd0);
        check("t5_rst_mem_wr",   {31'd0, bus.mem_wr},      32'd0);
        check("t5_rst_mem_cs",   {31'd0, bus.mem_cs},      32'd0);
        check("t5_rst_rdata",    {24'd0, bus.rdata},       32'd0);
        check("t5_rst_rvalid",   {31'd0, bus.rdata_valid}, 32'd0);
        check("t5_rst_rlast",    {31'd0, bus.rdata_last},  32'd0);
        snap_rd     = rd_data_q.size();
        snap_pulses = rd_pulses;
        #13 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("t5_no_rvalid_after", rd_data_q.size(), snap_rd);
        check("t5_no_rd_after",     rd_pulses,        snap_pulses);
        check("t5_idle_after",      {31'd0, bus.busy}, 32'd0);

        check("bus_protocol_violations", viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
